mem_loader: RTL and testbench

//  Byte-stream boot loader for the FlexPRET core. Receives framed commands from a byte

---
 rtl/mem_loader.sv | 244 ++++++++++++++++++++++++
 tb/tb_mem_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// mem_loader - byte-stream boot loader for the FlexPRET core.
//
// Receives framed commands from a byte source and turns them into word writes
// on the core's external imem/dmem write ports. The core is held in reset from
// any load command until a RUN command arrives.
//
// Frame: CMD, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, then LEN little-endian 32-bit
// words. RUN is a single-byte frame.
//
// Ports:
//   clk, reset              core clock, synchronous active-high reset
//   rx_valid/rx_data/rx_ready   byte input, transfer when valid & ready
//   core_reset              reset to the core, active-high
//   io_imem_*               imem write port (addr, write strobe, data)
//   io_dmem_*               dmem write port (addr, enable, byte lanes, data)
//   busy                    high whenever the FSM is not in IDLE
//   err                     sticky protocol error flag
//
// Optional feature: define LOADER_CHECKSUM_EN to expect one checksum byte after
// the last data word (8-bit sum of all data bytes of the frame).
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a command byte
// ADDR0 | receive low address byte
// ADDR1 | receive high address byte
// LEN0  | receive low word-count byte
// LEN1  | receive high word-count byte
// DATA  | collect 4 bytes of the current word
// WRITE | one-cycle write strobe, byte input stalled
// CHK   | receive and compare checksum byte (checksum build only)

module mem_loader #(
  parameter int          ADDR_W   = 12,
  parameter logic [7:0]  CMD_IMEM = 8'h01,
  parameter logic [7:0]  CMD_DMEM = 8'h02,
  parameter logic [7:0]  CMD_RUN  = 8'h03
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              core_reset,
  output logic [ADDR_W-1:0] io_imem_addr,
  output logic              io_imem_write,
  output logic [31:0]       io_imem_data_in,
  output logic [ADDR_W-1:0] io_dmem_addr,
  output logic              io_dmem_enable,
  output logic              io_dmem_byte_write_3,
  output logic              io_dmem_byte_write_2,
  output logic              io_dmem_byte_write_1,
  output logic              io_dmem_byte_write_0,
  output logic [31:0]       io_dmem_data_in,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE, ADDR0, ADDR1, LEN0, LEN1, DATA, WRITE, CHK
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t END_ST = CHK;
`else
  localparam state_t END_ST = IDLE;
`endif

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         len_q, len_d;
  logic [7:0]          lo_q, lo_d;
  logic [31:0]         word_q, word_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                dsel_q, dsel_d;
  logic                crst_q, crst_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   ia_q, ia_d, da_q, da_d;
  logic [31:0]         id_q, id_d, dd_q, dd_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  logic xfer;
  logic wr_cycle;

  assign rx_ready = (state_q != WRITE);
  assign xfer     = rx_valid && rx_ready;
  // Gated with reset so a reset landing on the WRITE cycle issues no strobe.
  assign wr_cycle = (state_q == WRITE) && !reset;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    lo_d    = lo_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    dsel_d  = dsel_q;
    crst_d  = crst_q;
    err_d   = err_q;
    ia_d    = ia_q;
    id_d    = id_q;
    da_d    = da_q;
    dd_d    = dd_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif

    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (rx_data == CMD_IMEM || rx_data == CMD_DMEM) begin
            state_d = ADDR0;
            crst_d  = 1'b1;
            err_d   = 1'b0;
            dsel_d  = (rx_data == CMD_DMEM);
            cnt_d   = 2'd0;
`ifdef LOADER_CHECKSUM_EN
            csum_d  = 8'h00;
`endif
          end else if (rx_data == CMD_RUN) begin
            crst_d = 1'b0;
            err_d  = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ADDR0: begin
        if (xfer) begin
          lo_d    = rx_data;
          state_d = ADDR1;
        end
      end
      ADDR1: begin
        if (xfer) begin
          // Upper address bits beyond ADDR_W are dropped.
          addr_d  = ADDR_W'({rx_data, lo_q});
          state_d = LEN0;
        end
      end
      LEN0: begin
        if (xfer) begin
          lo_d    = rx_data;
          state_d = LEN1;
        end
      end
      LEN1: begin
        if (xfer) begin
          len_d   = {rx_data, lo_q};
          state_d = ({rx_data, lo_q} == 16'd0) ? END_ST : DATA;
        end
      end
      DATA: begin
        if (xfer) begin
          // Shift right so the first byte of the word ends up in bits [7:0].
          word_d = {rx_data, word_q[31:8]};
          cnt_d  = cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q + rx_data;
`endif
          if (cnt_q == 2'd3) begin
            state_d = WRITE;
            if (dsel_q) begin
              da_d = addr_q;
              dd_d = word_d;
            end else begin
              ia_d = addr_q;
              id_d = word_d;
            end
          end
        end
      end
      WRITE: begin
        addr_d  = addr_q + ADDR_W'(1);
        len_d   = len_q - 16'd1;
        state_d = (len_q == 16'd1) ? END_ST : DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        if (xfer) begin
          if (rx_data != csum_q) err_d = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      lo_q    <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      dsel_q  <= 1'b0;
      crst_q  <= 1'b1;
      err_q   <= 1'b0;
      ia_q    <= '0;
      id_q    <= '0;
      da_q    <= '0;
      dd_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      lo_q    <= lo_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      dsel_q  <= dsel_d;
      crst_q  <= crst_d;
      err_q   <= err_d;
      ia_q    <= ia_d;
      id_q    <= id_d;
      da_q    <= da_d;
      dd_q    <= dd_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign core_reset           = crst_q;
  assign err                  = err_q;
  assign busy                 = (state_q != IDLE);
  assign io_imem_addr         = ia_q;
  assign io_imem_data_in      = id_q;
  assign io_imem_write        = wr_cycle && !dsel_q;
  assign io_dmem_addr         = da_q;
  assign io_dmem_data_in      = dd_q;
  assign io_dmem_enable       = wr_cycle && dsel_q;
  assign io_dmem_byte_write_3 = wr_cycle && dsel_q;
  assign io_dmem_byte_write_2 = wr_cycle && dsel_q;
  assign io_dmem_byte_write_1 = wr_cycle && dsel_q;
  assign io_dmem_byte_write_0 = wr_cycle && dsel_q;

endmodule

// File: tb/tb_mem_loader.sv
module tb_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        core_reset;
  logic [11:0] io_imem_addr;
  logic        io_imem_write;
  logic [31:0] io_imem_data_in;
  logic [11:0] io_dmem_addr;
  logic        io_dmem_enable;
  logic        bw3, bw2, bw1, bw0;
  logic [31:0] io_dmem_data_in;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;
  int iw_cnt = 0;
  int dw_cnt = 0;

  always #5 clk = ~clk;

  mem_loader dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .core_reset(core_reset),
    .io_imem_addr(io_imem_addr), .io_imem_write(io_imem_write),
    .io_imem_data_in(io_imem_data_in),
    .io_dmem_addr(io_dmem_addr), .io_dmem_enable(io_dmem_enable),
    .io_dmem_byte_write_3(bw3), .io_dmem_byte_write_2(bw2),
    .io_dmem_byte_write_1(bw1), .io_dmem_byte_write_0(bw0),
    .io_dmem_data_in(io_dmem_data_in), .busy(busy), .err(err)
  );

  always @(negedge clk) begin
    if (io_imem_write) iw_cnt++;
    if (io_dmem_enable) dw_cnt++;
  end

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        rdy, bsy, crst, er, iwr, dwr;
    logic [11:0] ia;
    logic [31:0] id;
    logic [11:0] da;
    logic [31:0] dd;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [7:0] d,
                     input logic rdy, input logic bsy, input logic crst, input logic er,
                     input logic iwr, input logic dwr,
                     input logic [11:0] ia, input logic [31:0] id,
                     input logic [11:0] da, input logic [31:0] dd);
    vec_t t;
    t.v = v; t.d = d; t.rdy = rdy; t.bsy = bsy; t.crst = crst; t.er = er;
    t.iwr = iwr; t.dwr = dwr; t.ia = ia; t.id = id; t.da = da; t.dd = dd;
    tbl.push_back(t);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  function automatic logic [9:0] ctl();
    return {rx_ready, busy, core_reset, err, io_imem_write, io_dmem_enable, bw3, bw2, bw1, bw0};
  endfunction

  task automatic send(input logic [7:0] b);
    bit ok;
    ok = 0;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (rx_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: byte 0x%0h not accepted, rx_ready=%0b, required 1", b, rx_ready);
    end
    @(posedge clk);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    rx_valid = 1'b0;
    #1;
  endtask

  localparam logic [11:0] IA1 = 12'h010, IA2 = 12'h011;
  localparam logic [31:0] ID1 = 32'hDEADBEEF, ID2 = 32'h12345678;
  localparam logic [31:0] DD1 = 32'h11223344, DD2 = 32'h55667788;

  initial begin
    int iw0, dw0;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("reset_ctl", 0, {22'd0, ctl()}, {22'd0, 10'b1010_000000});
    chk("reset_iaddr", 0, {20'd0, io_imem_addr}, 32'd0);
    chk("reset_idata", 0, io_imem_data_in, 32'd0);
    chk("reset_daddr", 0, {20'd0, io_dmem_addr}, 32'd0);
    chk("reset_ddata", 0, io_dmem_data_in, 32'd0);
    chk("reset_strobes", 0, iw_cnt + dw_cnt, 0);

    // imem frame: 2 words at 0x010
    add(1, 8'h01, 1,0,1,0, 0,0, 0,0,0,0);
    add(1, 8'h10, 1,1,1,0, 0,0, 0,0,0,0);
    add(1, 8'h00, 1,1,1,0, 0,0, 0,0,0,0);
    add(1, 8'h02, 1,1,1,0, 0,0, 0,0,0,0);
    add(1, 8'h00, 1,1,1,0, 0,0, 0,0,0,0);
    add(1, 8'hEF, 1,1,1,0, 0,0, 0,0,0,0);
    add(1, 8'hBE, 1,1,1,0, 0,0, 0,0,0,0);
    add(1, 8'hAD, 1,1,1,0, 0,0, 0,0,0,0);
    add(1, 8'hDE, 1,1,1,0, 0,0, 0,0,0,0);
    add(1, 8'h78, 0,1,1,0, 1,0, IA1,ID1,0,0);
    add(1, 8'h78, 1,1,1,0, 0,0, IA1,ID1,0,0);
    add(1, 8'h56, 1,1,1,0, 0,0, IA1,ID1,0,0);
    add(1, 8'h34, 1,1,1,0, 0,0, IA1,ID1,0,0);
    add(1, 8'h12, 1,1,1,0, 0,0, IA1,ID1,0,0);
    add(0, 8'h00, 0,1,1,0, 1,0, IA2,ID2,0,0);
`ifdef LOADER_CHECKSUM_EN
    add(1, 8'h4C, 1,1,1,0, 0,0, IA2,ID2,0,0);
`endif
    add(0, 8'h00, 1,0,1,0, 0,0, IA2,ID2,0,0);
    // RUN releases the core
    add(1, 8'h03, 1,0,1,0, 0,0, IA2,ID2,0,0);
    add(0, 8'h00, 1,0,0,0, 0,0, IA2,ID2,0,0);
    // unknown command sets err, RUN clears it
    add(1, 8'h7E, 1,0,0,0, 0,0, IA2,ID2,0,0);
    add(0, 8'h00, 1,0,0,1, 0,0, IA2,ID2,0,0);
    add(1, 8'h03, 1,0,0,1, 0,0, IA2,ID2,0,0);
    add(0, 8'h00, 1,0,0,0, 0,0, IA2,ID2,0,0);
    // dmem frame at 0xFFF, wraps to 0x000
    add(1, 8'h02, 1,0,0,0, 0,0, IA2,ID2,0,0);
    add(1, 8'hFF, 1,1,1,0, 0,0, IA2,ID2,0,0);
    add(1, 8'h0F, 1,1,1,0, 0,0, IA2,ID2,0,0);
    add(1, 8'h02, 1,1,1,0, 0,0, IA2,ID2,0,0);
    add(1, 8'h00, 1,1,1,0, 0,0, IA2,ID2,0,0);
    add(1, 8'h44, 1,1,1,0, 0,0, IA2,ID2,0,0);
    add(1, 8'h33, 1,1,1,0, 0,0, IA2,ID2,0,0);
    add(1, 8'h22, 1,1,1,0, 0,0, IA2,ID2,0,0);
    add(1, 8'h11, 1,1,1,0, 0,0, IA2,ID2,0,0);
    add(1, 8'h88, 0,1,1,0, 0,1, IA2,ID2,12'hFFF,DD1);
    add(1, 8'h88, 1,1,1,0, 0,0, IA2,ID2,12'hFFF,DD1);
    add(1, 8'h77, 1,1,1,0, 0,0, IA2,ID2,12'hFFF,DD1);
    add(1, 8'h66, 1,1,1,0, 0,0, IA2,ID2,12'hFFF,DD1);
    add(1, 8'h55, 1,1,1,0, 0,0, IA2,ID2,12'hFFF,DD1);
    add(0, 8'h00, 0,1,1,0, 0,1, IA2,ID2,12'h000,DD2);
`ifdef LOADER_CHECKSUM_EN
    add(1, 8'h64, 1,1,1,0, 0,0, IA2,ID2,12'h000,DD2);
`endif
    add(0, 8'h00, 1,0,1,0, 0,0, IA2,ID2,12'h000,DD2);

    foreach (tbl[i]) begin
      @(negedge clk);
      rx_valid = tbl[i].v;
      rx_data  = tbl[i].d;
      #1;
      chk("ctl", i, {22'd0, ctl()},
          {22'd0, tbl[i].rdy, tbl[i].bsy, tbl[i].crst, tbl[i].er, tbl[i].iwr,
           tbl[i].dwr, tbl[i].dwr, tbl[i].dwr, tbl[i].dwr, tbl[i].dwr});
      chk("imem_addr", i, {20'd0, io_imem_addr}, {20'd0, tbl[i].ia});
      chk("imem_data", i, io_imem_data_in, tbl[i].id);
      chk("dmem_addr", i, {20'd0, io_dmem_addr}, {20'd0, tbl[i].da});
      chk("dmem_data", i, io_dmem_data_in, tbl[i].dd);
    end
    chk("imem_write_count", 0, iw_cnt, 2);
    chk("dmem_write_count", 0, dw_cnt, 2);

    // Reset after 2 of 4 data bytes: no write, back to reset values.
    send(8'h01); send(8'h20); send(8'h00); send(8'h01); send(8'h00);
    send(8'hAA); send(8'hBB);
    iw0 = iw_cnt;
    @(negedge clk);
    reset = 1'b1; rx_valid = 1'b1; rx_data = 8'hCC;
    @(negedge clk);
    reset = 1'b0; rx_valid = 1'b0;
    #1;
    chk("midreset_ctl", 0, {22'd0, ctl()}, {22'd0, 10'b1010_000000});
    chk("midreset_iaddr", 0, {20'd0, io_imem_addr}, 32'd0);
    repeat (6) idle_cycle();
    chk("midreset_nowrite", 0, iw_cnt, iw0);

    // Reset landing exactly on the WRITE cycle suppresses the strobe.
    send(8'h01); send(8'h20); send(8'h00); send(8'h01); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    @(negedge clk);
    rx_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("reset_in_write_strobe", 0, {31'd0, io_imem_write}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_in_write_busy", 0, {31'd0, busy}, 32'd0);

    // LEN == 0: no write, frame ends.
    iw0 = iw_cnt; dw0 = dw_cnt;
    send(8'h01); send(8'h34); send(8'h12); send(8'h00); send(8'h00);
`ifdef LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    idle_cycle();
    chk("len0_ctl", 0, {22'd0, ctl()}, {22'd0, 10'b1010_000000});
    repeat (3) idle_cycle();
    chk("len0_nowrite", 0, iw_cnt + dw_cnt, iw0 + dw0);

`ifdef LOADER_CHECKSUM_EN
    // One word with wrong checksum (correct is 0x0A): write happens, err set.
    iw0 = iw_cnt;
    send(8'h01); send(8'h05); send(8'h00); send(8'h01); send(8'h00);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'hFF);
    idle_cycle();
    chk("chk_err", 0, {31'd0, err}, 32'd1);
    chk("chk_addr", 0, {20'd0, io_imem_addr}, 32'h005);
    chk("chk_data", 0, io_imem_data_in, 32'h04030201);
    chk("chk_write", 0, iw_cnt, iw0 + 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached, required finish");
    $fatal(1, "timeout");
  end

endmodule
